// File: rtl/seg7_digit_scanner.sv
// rtl/seg7_digit_scanner.sv - multiplexed common-anode 7-segment scanner with frame-committed double buffer
// Optional leading-zero suppression: define SEG7_LZS_EN.
module seg7_digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              nibble_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("seg7_digit_scanner: PRESCALE must be >= 2");
  end
  if (BLANK_CYCLES >= PRESCALE) begin : g_bad_blank
    $error("seg7_digit_scanner: BLANK_CYCLES must be < PRESCALE");
  end

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d, active_q, active_d;
  logic [NUM_DIGITS-1:0]   pending_dp_q, pending_dp_d, active_dp_q, active_dp_d;
  logic                    pending_valid_q, pending_valid_d;
  logic [3:0]              nibble_q, nibble_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_n_q, en_n_d;
  logic                    tick_q, tick_d;
  logic                    cnt_wrap, boundary, lit_d;

  always_comb begin
    cnt_wrap        = (cnt_q == CNT_MAX);
    boundary        = cnt_wrap && (idx_q == IDX_MAX);
    cnt_d           = cnt_wrap ? '0 : cnt_q + CW'(1);
    idx_d           = idx_q;
    if (cnt_wrap) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);

    pending_d       = pending_q;
    pending_dp_d    = pending_dp_q;
    pending_valid_d = pending_valid_q;
    active_d        = active_q;
    active_dp_d     = active_dp_q;
    // A load on the boundary edge bypasses pending so it shows in the new frame.
    if (boundary) begin
      pending_valid_d = 1'b0;
      if (value_load) begin
        active_d    = value_in;
        active_dp_d = dp_in;
      end else if (pending_valid_q) begin
        active_d    = pending_q;
        active_dp_d = pending_dp_q;
      end
    end else if (value_load) begin
      pending_d       = value_in;
      pending_dp_d    = dp_in;
      pending_valid_d = 1'b1;
    end
  end

`ifdef SEG7_LZS_EN
  logic [IW-1:0] top_d;
  // Highest digit that must stay lit: nonzero nibble or requested decimal point.
  always_comb begin
    top_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((active_d[4*k +: 4] != 4'h0) || active_dp_d[k]) top_d = IW'(k);
    end
    lit_d = (idx_d <= top_d);
  end
`else
  assign lit_d = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d >= BLANK_END) state_d = ST_DRIVE;
      ST_DRIVE: if (cnt_d < BLANK_END) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase

    nibble_d = 4'h0;
    dp_d     = 1'b0;
    en_n_d   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        nibble_d = active_d[4*k +: 4];
        dp_d     = active_dp_d[k];
        if (state_d == ST_DRIVE && lit_d) en_n_d[k] = 1'b0;
      end
    end
    tick_d = boundary;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_BLANK;
      cnt_q           <= '0;
      idx_q           <= '0;
      pending_q       <= '0;
      pending_dp_q    <= '0;
      pending_valid_q <= 1'b0;
      active_q        <= '0;
      active_dp_q     <= '0;
      nibble_q        <= 4'h0;
      dp_q            <= 1'b0;
      en_n_q          <= '1;
      tick_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      pending_q       <= pending_d;
      pending_dp_q    <= pending_dp_d;
      pending_valid_q <= pending_valid_d;
      active_q        <= active_d;
      active_dp_q     <= active_dp_d;
      nibble_q        <= nibble_d;
      dp_q            <= dp_d;
      en_n_q          <= en_n_d;
      tick_q          <= tick_d;
    end
  end

  assign nibble_out = nibble_q;
  assign dp_out     = dp_q;
  assign digit_en_n = en_n_q;
  assign frame_tick = tick_q;

endmodule
